// File: rtl/key_expand_seq.sv
// rtl/key_expand_seq.sv - AES-128 key-schedule sequencer streaming round keys 0..NR
// Optional round-key register file is enabled by defining KEY_EXP_STORE_EN.
module key_expand_seq #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
`ifdef KEY_EXP_STORE_EN
  input  logic [3:0]   rk_rd_idx,
  output logic [127:0] rk_rd_data,
`endif
  output logic         rk_valid,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;

  localparam logic [3:0] NR_W = 4'(NR);

  // One row per high nibble; the first byte of each row sits in the top bits.
  localparam logic [127:0] SBOX_ROW [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    logic [127:0] r;
    r = SBOX_ROW[x[7:4]] >> {~x[3:0], 3'b000};
    return r[7:0];
  endfunction

  state_t       state_q, state_d;
  logic         rk_valid_q, rk_valid_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rk_round_q, rk_round_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [7:0]   rcon_q, rcon_d;

  logic [31:0]  rotword, subed, t;
  logic [31:0]  w0n, w1n, w2n, w3n;
  logic [127:0] rk_next;
  logic         xfer;
  logic         last_round;

  // Key-schedule step: RotWord -> SubWord -> Rcon, then the chained word XORs.
  always_comb begin
    rotword = {rk_q[23:0], rk_q[31:24]};
    subed   = {sub_byte(rotword[31:24]), sub_byte(rotword[23:16]),
               sub_byte(rotword[15:8]),  sub_byte(rotword[7:0])};
    t       = subed ^ {rcon_q, 24'h0};
    w0n     = rk_q[127:96] ^ t;
    w1n     = rk_q[95:64]  ^ w0n;
    w2n     = rk_q[63:32]  ^ w1n;
    w3n     = rk_q[31:0]   ^ w2n;
    rk_next = {w0n, w1n, w2n, w3n};
  end

  assign xfer       = rk_valid_q & rk_ready;
  assign last_round = (rk_round_q == NR_W);

  always_comb begin
    state_d    = state_q;
    rk_valid_d = rk_valid_q;
    rk_d       = rk_q;
    rk_round_d = rk_round_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rcon_d     = rcon_q;
    case (state_q)
      IDLE: begin
        rk_valid_d = 1'b0;
        rk_d       = '0;
        rk_round_d = '0;
        busy_d     = 1'b0;
        rcon_d     = 8'h01;
        if (start) begin
          state_d    = EMIT;
          rk_valid_d = 1'b1;
          busy_d     = 1'b1;
          rk_d       = key_in;
        end
      end
      EMIT: begin
        if (xfer) begin
          if (last_round) begin
            rk_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = FIN;
          end else begin
            rk_d       = rk_next;
            rk_round_d = rk_round_q + 4'd1;
            rcon_d     = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
          end
        end
      end
      FIN: begin
        // Last key stays visible alongside done; IDLE then shows reset values.
        state_d    = IDLE;
        rk_d       = '0;
        rk_round_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef KEY_EXP_STORE_EN
  logic [127:0] store_q [0:10];
  logic [127:0] store_d [0:10];

  always_comb begin
    store_d = store_q;
    if (state_q == IDLE && start) begin
      store_d[0] = key_in;
    end else if (state_q == EMIT && xfer && !last_round) begin
      store_d[rk_round_q + 4'd1] = rk_next;
    end
  end

  assign rk_rd_data = (rk_rd_idx <= NR_W) ? store_q[rk_rd_idx] : '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rk_valid_q <= 1'b0;
      rk_q       <= '0;
      rk_round_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rcon_q     <= 8'h01;
`ifdef KEY_EXP_STORE_EN
      for (int i = 0; i < 11; i++) store_q[i] <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rk_valid_q <= rk_valid_d;
      rk_q       <= rk_d;
      rk_round_q <= rk_round_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rcon_q     <= rcon_d;
`ifdef KEY_EXP_STORE_EN
      store_q    <= store_d;
`endif
    end
  end

  assign rk_valid = rk_valid_q;
  assign rk       = rk_q;
  assign rk_round = rk_round_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_key_expand_seq.sv
// tb/tb_key_expand_seq.sv - randomized self-checking bench for key_expand_seq
// Reference schedule is derived from GF(2^8) arithmetic, independent of any table.
module tb_key_expand_seq;

  localparam int NR = 10;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         reset, start, rk_ready;
  logic [127:0] key_in;
  logic         rk_valid, busy, done;
  logic [127:0] rk;
  logic [3:0]   rk_round;
`ifdef KEY_EXP_STORE_EN
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [0:10];
  logic [127:0] got_rk [0:10];

  key_expand_seq #(.NR(NR)) dut (
    .clk(clk), .reset(reset), .start(start), .key_in(key_in), .rk_ready(rk_ready),
`ifdef KEY_EXP_STORE_EN
    .rk_rd_idx(rk_rd_idx), .rk_rd_data(rk_rd_data),
`endif
    .rk_valid(rk_valid), .rk(rk), .rk_round(rk_round), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    if (a == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gf_mul(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tw;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {tw[23:0], tw[31:24]};
        tw = {sb[tw[31:24]], sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]]} ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int r = 0; r <= NR; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic run(input logic [127:0] key, input int stall_at, input int stall_len,
                     input int inj_at, input int abort_at);
    int n, nxt, stalled;
    bit injected, fin;
    model_expand(key);
    for (int r = 0; r <= NR; r++) got_rk[r] = 'x;
    nxt = 0; stalled = 0; injected = 0; fin = 0;
    start = 1'b1; key_in = key; rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; key_in = rand128();
    n = 1;
    while (!fin && n < 80) begin
      if (abort_at >= 0 && nxt == abort_at) begin
        reset = 1'b1;
        #1;
        check("abort_valid", rk_valid, 0);
        check("abort_rk", rk, 0);
        check("abort_round", rk_round, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        check("abort_nodone", done, 0);
        reset = 1'b0;
        return;
      end
      if (done) begin
        check("done_cycle", n, NR + 2 + stalled);
        check("round_count", nxt, NR + 1);
        check("fin_valid", rk_valid, 0);
        check("fin_busy", busy, 0);
        check("fin_rk", rk, exp_rk[NR]);
        check("fin_round", rk_round, NR);
        start = 1'b1; key_in = rand128();
        @(negedge clk);
        start = 1'b0;
        check("idle_done", done, 0);
        check("idle_valid", rk_valid, 0);
        check("idle_rk", rk, 0);
        fin = 1;
      end else begin
        check("valid", rk_valid, 1);
        check("busy", busy, 1);
        check("round", rk_round, nxt);
        check("rk", rk, exp_rk[nxt]);
        got_rk[rk_round] = rk;
        start = 1'b0;
        if (inj_at >= 0 && nxt == inj_at && !injected) begin
          start = 1'b1; key_in = rand128(); injected = 1;
        end
        if (nxt == stall_at && stalled < stall_len) begin
          rk_ready = 1'b0; stalled++;
        end else begin
          rk_ready = 1'b1; nxt++;
        end
        @(negedge clk);
        n++;
      end
    end
    check("terminated", fin, 1);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) sb[a] = sbox_ref(8'(a));
    reset = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0;
`ifdef KEY_EXP_STORE_EN
    rk_rd_idx = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_valid", rk_valid, 0);
    check("rst_rk", rk, 0);
    check("rst_round", rk_round, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    key_in = rand128(); rk_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_nostart_valid", rk_valid, 0);
    check("idle_nostart_rk", rk, 0);

    run(FIPS_KEY, -1, 0, -1, -1);
    check("fips_r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`ifdef KEY_EXP_STORE_EN
    rk_rd_idx = 4'd10; #1;
    check("store_r10", rk_rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rk_rd_idx = 4'd0; #1;
    check("store_r0", rk_rd_data, FIPS_KEY);
    rk_rd_idx = 4'd11; #1;
    check("store_r11", rk_rd_data, 0);
    @(negedge clk);
`endif

    run(128'h0, -1, 0, -1, -1);
    check("zero_r1", got_rk[1], 128'h62636363626363636263636362636363);

    run(FIPS_KEY, 4, 3, -1, -1);
    run(FIPS_KEY, -1, 0, 5, -1);
    run(rand128(), -1, 0, -1, 6);
    run(FIPS_KEY, -1, 0, -1, -1);
    check("fresh_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    for (int k = 0; k < 6; k++) begin
      run(rand128(), int'($urandom_range(0, NR)), int'($urandom_range(0, 4)),
          int'($urandom_range(0, NR)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
